pulp_clock_divider: RTL and testbench
=====================================

# pulp_clock_divider

Programmable integer clock divider driven from a single reference clock. It generates a glitch-free divided clock `clk_o` by toggling a register, never by combinational muxing of clocks. The divisor is reprogrammed through a valid/ready handshake and takes effect only at a period boundary. Start and stop are also aligned to period boundaries, so `clk_o` never shows a shortened pulse, except under reset. It sits next to the clock buffer/gating cells in SoC clock generation and feeds peripheral clocks and their clock-enable logic.

## Interface
Parameters:
- `DIV_WIDTH`, 8: width of the divisor.
- `DEFAULT_DIV`, 2: divisor loaded at reset. Must be ≥ 2.

Ports:
- `clk_i`, in, 1: reference clock. Single clock domain.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: run request. Level-sensitive.
- `cfg_valid_i`, in, 1: new divisor offered.
- `cfg_ready_o`, out, 1: divisor can be accepted.
- `cfg_div_i`, in, DIV_WIDTH: requested divisor N. Values 0 and 1 are clamped to 2.
- `clk_o`, out, 1: divided clock, registered.
- `tick_o`, out, 1: high during the first `clk_i` cycle of every `clk_o` high phase.
- `busy_o`, out, 1: high while in RUN.

## Operation
- Internal state:
  - `div_q`: active divisor.
  - `pend_q`/`pdiv_q`: one-entry pending update.
  - `cnt_q`: 0..N-1, DIV_WIDTH bits.
  - FSM {IDLE, RUN}.
- Waveform for active divisor N, with H = floor(N/2):
  - Each period lasts N `clk_i` cycles.
  - `clk_o` is 1 for the first H cycles (cnt 0..H-1) and 0 for the remaining N-H cycles.
  - Examples: N=2 → 10, N=3 → 100, N=4 → 1100, N=5 → 11000.
- IDLE:
  - `clk_o`=0, `cnt_q` held at 0, `busy_o`=0.
  - When `en_i` is sampled 1, go to RUN; cnt=0 begins the next cycle.
- RUN:
  - `cnt_q` increments each cycle.
  - On the last cycle of a period (cnt==N-1), at the closing edge:
    - If a pending update exists, `div_q`←`pdiv_q` and pending clears.
    - If `en_i`=1, start a new period (cnt←0). If `en_i`=0, go to IDLE.
  - Dropping `en_i` mid-period always completes the current period; no truncation.
  - Re-asserting `en_i` before the period ends continues seamlessly, with no gap cycle.
- Config handshake:
  - Transfer occurs when `cfg_valid_i & cfg_ready_o` at a rising edge. The clamped value is captured.
  - `cfg_ready_o` = !`pend_q`. Ready is combinational only on the register, never on inputs.
  - In IDLE, an accepted divisor is written directly to `div_q`; pending stays 0 and ready stays 1.
  - In RUN, an accepted divisor is written to `pdiv_q` and `pend_q`←1. Ready then stays low until it is applied at the period end.
  - Acceptance on the same edge as a period end (cnt==N-1) applies to the immediately following period and bypasses pending. Ready remains high.
- `tick_o` = RUN & cnt_q==0.

## Timing
- Reset values: `clk_o`=0, `tick_o`=0, `busy_o`=0, `cfg_ready_o`=1, FSM=IDLE, `cnt_q`=0, `div_q`=DEFAULT_DIV, `pend_q`=0.
- Reset mid-operation: all outputs return to reset values in the cycle after the reset edge. This may truncate a high phase; that is accepted.
- Start latency: `en_i` sampled 1 at edge k → `clk_o`=1 and `tick_o`=1 in cycle k+1.
- Stop latency: `clk_o` is 0 and `busy_o` falls in the cycle after the closing edge of the period in which `en_i` was last sampled 0 at period end.
- Divisor change latency: from acceptance to new period length is at most one full old period.
- Counter arithmetic:
  - Compare cnt against N-1 using DIV_WIDTH-bit unsigned arithmetic.
  - N = 2^DIV_WIDTH-1 is legal. No overflow is possible since cnt ≤ N-1.
- All outputs are registered or derived only from registers. No path exists from `clk_i` to `clk_o` except through a flop.

## Test plan
- Reset then `en_i`=1 with DEFAULT_DIV=2 → `clk_o` = 1010…, `tick_o` high in every `clk_o`-high cycle, `busy_o`=1 from cycle 1.
- In IDLE, configure N=5, then enable → `clk_o` = 11000 repeating; `cfg_ready_o` stays 1 throughout.
- Running N=4 (1100), program N=3 at cnt=1:
  - `cfg_ready_o` drops the next cycle.
  - The current period ends as 1100, followed by 100 repeating.
  - Ready returns to 1 at the first N=3 period.
  - A second offer while ready is low is not accepted.
- Config accepted exactly at cnt==N-1 with N=6 → the next period is 6 cycles (111000); `cfg_ready_o` never drops. Offering `cfg_div_i`=0 or 1 produces N=2.
- Running N=6, drop `en_i` at cnt=1 → the period completes as 111000, then `clk_o`=0 and `busy_o`=0. Re-raising `en_i` at cnt=4 of a later run gives no gap between periods.
- Assert `rst_i` at cnt=1 of N=4 → next cycle `clk_o`=0, `busy_o`=0, `cfg_ready_o`=1, and the divisor reverts to DEFAULT_DIV.

Source files
------------

// File: rtl/pulp_clock_divider.sv
// Programmable integer clock divider: clk_o is a flop output toggled on period
// boundaries of a counter running on clk_i, with handshake-loaded divisor.
module pulp_clock_divider #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 clk_o,
  output logic                 tick_o,
  output logic                 busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DIV_WIDTH-1:0] MinDiv   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ResetDiv = DIV_WIDTH'(DEFAULT_DIV);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 busy_q, busy_d;

  logic                 accept_c;
  logic                 last_c;
  logic [DIV_WIDTH-1:0] cdiv_c;

  // Handshake and period-end decode, all from registers except the offer itself
  always_comb begin
    accept_c = cfg_valid_i & ~pend_q;
    cdiv_c   = (cfg_div_i < MinDiv) ? MinDiv : cfg_div_i;
    last_c   = (state_q == RUN) && (cnt_q == (div_q - DIV_WIDTH'(1)));
  end

  // Next-state: counter, divisor update path and run/idle sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          div_d = cdiv_c;
        end
        if (en_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (last_c) begin
          // Period boundary: apply pending or same-edge divisor, then wrap or stop
          if (pend_q) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
          end
          if (accept_c) begin
            div_d = cdiv_c;
          end
          cnt_d = '0;
          if (!en_i) begin
            state_d = IDLE;
          end
        end else if (accept_c) begin
          pdiv_d = cdiv_c;
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == RUN);
    clk_d  = busy_d && (cnt_d < (div_d >> 1));
    tick_d = busy_d && (cnt_d == '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= ResetDiv;
      pdiv_q  <= ResetDiv;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign clk_o       = clk_q;
  assign tick_o      = tick_q;
  assign busy_o      = busy_q;
  assign cfg_ready_o = ~pend_q;

endmodule

// File: tb/tb_pulp_clock_divider.sv
// Scoreboard bench for pulp_clock_divider: stimulus pushes the expected
// {clk_o, tick_o, busy_o, cfg_ready_o} for the cycle after each edge, a monitor pops and compares.
module tb_pulp_clock_divider;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic [7:0] cfg_div_i = 8'd0;
  logic       clk_o;
  logic       tick_o;
  logic       busy_o;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t cur;
  int        n_cmp  = 0;
  int        n_fail = 0;
  logic [3:0] act;

  pulp_clock_divider #(
    .DIV_WIDTH  (8),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_div_i  (cfg_div_i),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: outputs are sampled 1 time unit after each rising edge
  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {clk_o, tick_o, busy_o, cfg_ready_o};
      n_cmp++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: clk/tick/busy/rdy got %b expected %b (t=%0t)", cur.name, act, cur.exp, $time);
      end
    end
  end

  // Drive inputs for the next edge and queue the outputs expected after it
  task automatic step(input logic rst, input logic en, input logic vld, input logic [7:0] div,
                      input logic [3:0] exp, input string nm);
    sb_entry_t e;
    @(negedge clk_i);
    rst_i       = rst;
    en_i        = en;
    cfg_valid_i = vld;
    cfg_div_i   = div;
    e.exp  = exp;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // One full running period of length n: high for floor(n/2) cycles, tick on the first
  task automatic expect_period(input int n, input logic rdy, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd0, {(i < n / 2), (i == 0), 1'b1, rdy}, nm);
    end
  endtask

  initial begin
    // Reset values
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "reset_a");
    step(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "reset_b");

    // Default divisor 2 -> 1010...
    repeat (3) expect_period(2, 1'b1, "div2_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "div2_stop");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "idle_hold");

    // Configure 5 in IDLE, ready never drops
    step(1'b0, 1'b0, 1'b1, 8'd5, 4'b0001, "cfg5_idle");
    repeat (2) expect_period(5, 1'b1, "div5_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "div5_stop");

    // Running 4, program 3 at cnt=1; second offer while not ready is ignored
    step(1'b0, 1'b0, 1'b1, 8'd4, 4'b0001, "cfg4_idle");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "n4_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1011, "n4_c1");
    step(1'b0, 1'b1, 1'b1, 8'd3, 4'b0010, "pend_c2");
    step(1'b0, 1'b1, 1'b1, 8'd7, 4'b0010, "blocked_offer_c3");
    repeat (2) expect_period(3, 1'b1, "div3_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "div3_stop");

    // Acceptance on the period-end edge bypasses pending; clamp of 0 and 1
    step(1'b0, 1'b0, 1'b1, 8'd4, 4'b0001, "cfg4_idle_b");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "b4_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1011, "b4_c1");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "b4_c2");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "b4_c3");
    step(1'b0, 1'b1, 1'b1, 8'd6, 4'b1111, "bypass6_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1011, "bypass6_c1");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1011, "bypass6_c2");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "bypass6_c3");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "bypass6_c4");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "bypass6_c5");
    step(1'b0, 1'b1, 1'b1, 8'd0, 4'b1111, "clamp0_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "clamp0_c1");
    step(1'b0, 1'b1, 1'b1, 8'd1, 4'b1111, "clamp1_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "clamp1_c1");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "clamp_stop");

    // Running 6, drop en at cnt=1: period completes, then idle
    step(1'b0, 1'b0, 1'b1, 8'd6, 4'b0001, "cfg6_idle");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "d6_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1011, "d6_c1");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b1011, "drop_c2");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0011, "drop_c3");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0011, "drop_c4");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0011, "drop_c5");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "drop_idle");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "drop_idle_b");

    // Re-raise en at cnt=4 of a later run: seamless next period
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "rr_c0");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b1011, "rr_c1");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b1011, "rr_c2");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0011, "rr_c3");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0011, "rr_c4");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "rr_c5");
    expect_period(6, 1'b1, "no_gap");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "rr_stop");

    // Reset at cnt=1 of N=4 with an update pending: everything reverts
    step(1'b0, 1'b0, 1'b1, 8'd4, 4'b0001, "cfg4_idle_c");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "r4_c0");
    step(1'b0, 1'b1, 1'b1, 8'd7, 4'b1010, "r4_c1_pend");
    step(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "rst_mid");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "post_rst_c0");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "post_rst_c1");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b1111, "post_rst_c0b");
    step(1'b0, 1'b1, 1'b0, 8'd0, 4'b0011, "post_rst_c1b");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "post_rst_stop");

    // Largest divisor 255: 127 high, 128 low
    step(1'b0, 1'b0, 1'b1, 8'd255, 4'b0001, "cfg255_idle");
    repeat (2) expect_period(255, 1'b1, "div255_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, "div255_stop");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
      @(posedge clk_i);
    end
    #2;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
